// File: rtl/onchip_mem_pkg.sv
// Shared types and constants for the pipelined on-chip RAM.
package onchip_mem_pkg;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_INIT  = 2'd1,
    ST_READY = 2'd2
  } state_e;

  localparam int MAX_READ_LATENCY = 2;
  localparam int BYTE_W           = 8;

  // Bit width needed to index n entries, never less than 1.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/onchip_mem_ram_core.sv
// Byte-enabled single-port RAM array with a registered read port.
// INIT_FILE is handed to the FPGA toolchain as the array's power-up image.
module onchip_mem_ram_core
  import onchip_mem_pkg::*;
#(
  parameter int    DATA_W    = 32,
  parameter int    DEPTH     = 23040,
  parameter int    IDX_W     = 15,
  parameter string INIT_FILE = "onchip_mem.hex"
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic                     i_re,
  input  logic [DATA_W/BYTE_W-1:0] i_be,
  input  logic [IDX_W-1:0]         i_addr,
  input  logic [DATA_W-1:0]        i_wdata,
  output logic [DATA_W-1:0]        o_rdata
);

  localparam int NB = DATA_W / BYTE_W;

  (* ram_init_file = INIT_FILE *)
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Read register only loads on a real read so the output holds between reads.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < NB; b++) begin
        if (i_be[b]) r_mem[i_addr][b*BYTE_W +: BYTE_W] <= i_wdata[b*BYTE_W +: BYTE_W];
      end
    end
    if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/onchip_mem_pipelined.sv
// Avalon-MM slave on-chip RAM with pipelined reads, clock-enable stall and range check.
// Define ONCHIP_MEM_ZERO_INIT_EN to sweep zeros through the whole array after reset.
module onchip_mem_pipelined
  import onchip_mem_pkg::*;
#(
  parameter int    DATA_W       = 32,
  parameter int    DEPTH        = 23040,
  parameter int    ADDR_W       = 15,
  parameter int    READ_LATENCY = 1,
  parameter string INIT_FILE    = "onchip_mem.hex"
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic [ADDR_W-1:0]        i_address,
  input  logic [DATA_W/BYTE_W-1:0] i_byteenable,
  input  logic                     i_chipselect,
  input  logic                     i_read,
  input  logic                     i_write,
  input  logic [DATA_W-1:0]        i_writedata,
  input  logic                     i_clken,
  output logic                     o_waitrequest,
  output logic [DATA_W-1:0]        o_readdata,
  output logic                     o_readdatavalid
);

  localparam int              IDX_W   = clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);

  state_e             r_state, w_state_nxt;
  logic               w_req, w_acc_rd, w_acc_wr, w_in_range, w_sweep;
  logic               w_core_we, w_core_re;
  logic [IDX_W-1:0]   w_core_addr, w_sweep_addr;
  logic [DATA_W/BYTE_W-1:0] w_core_be;
  logic [DATA_W-1:0]  w_core_wdata, w_core_rdata, w_rdata1;
  logic               r_vld1, r_zero1;

`ifdef ONCHIP_MEM_ZERO_INIT_EN
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  logic [IDX_W-1:0] r_sweep;

  // RESET with reset_n high already writes word 0, so the sweep is exactly DEPTH cycles.
  assign w_sweep      = (r_state != ST_READY);
  assign w_sweep_addr = r_sweep;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n)             r_sweep <= '0;
    else if (i_clken && w_sweep) r_sweep <= r_sweep + 1'b1;
  end
`else
  assign w_sweep      = 1'b0;
  assign w_sweep_addr = '0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_reset_n)   r_state <= ST_RESET;
    else if (i_clken) r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
`ifdef ONCHIP_MEM_ZERO_INIT_EN
      ST_RESET: w_state_nxt = (r_sweep == LAST_IDX) ? ST_READY : ST_INIT;
      ST_INIT:  if (r_sweep == LAST_IDX) w_state_nxt = ST_READY;
`endif
      ST_READY: w_state_nxt = ST_READY;
      default:  w_state_nxt = ST_READY;
    endcase
  end

  assign w_in_range = ({1'b0, i_address} < DEPTH_V);

  always_comb begin
    o_waitrequest = (r_state != ST_READY) | ~i_clken;
    w_req         = i_chipselect & (i_read | i_write) & ~o_waitrequest;
    w_acc_wr      = w_req & i_write;
    w_acc_rd      = w_req & i_read & ~i_write;
    w_core_we     = i_reset_n & ((w_sweep & i_clken) | (w_acc_wr & w_in_range));
    w_core_re     = i_reset_n & w_acc_rd & w_in_range;
    w_core_addr   = w_sweep ? w_sweep_addr : i_address[IDX_W-1:0];
    w_core_be     = w_sweep ? '1 : i_byteenable;
    w_core_wdata  = w_sweep ? '0 : i_writedata;
  end

  onchip_mem_ram_core #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .IDX_W     (IDX_W),
    .INIT_FILE (INIT_FILE)
  ) u_ram_core (
    .i_clk   (i_clk),
    .i_we    (w_core_we),
    .i_re    (w_core_re),
    .i_be    (w_core_be),
    .i_addr  (w_core_addr),
    .i_wdata (w_core_wdata),
    .o_rdata (w_core_rdata)
  );

  // r_zero1 masks the RAM output for out-of-range reads and after reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_vld1  <= 1'b0;
      r_zero1 <= 1'b1;
    end else if (i_clken) begin
      r_vld1 <= w_acc_rd;
      if (w_acc_rd) r_zero1 <= ~w_in_range;
    end
  end

  assign w_rdata1 = r_zero1 ? '0 : w_core_rdata;

  generate
    if (READ_LATENCY >= MAX_READ_LATENCY) begin : g_lat2
      logic              r_vld2;
      logic [DATA_W-1:0] r_rdata2;

      always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
          r_vld2   <= 1'b0;
          r_rdata2 <= '0;
        end else if (i_clken) begin
          r_vld2 <= r_vld1;
          if (r_vld1) r_rdata2 <= w_rdata1;
        end
      end

      assign o_readdatavalid = r_vld2;
      assign o_readdata      = r_rdata2;
    end else begin : g_lat1
      assign o_readdatavalid = r_vld1;
      assign o_readdata      = w_rdata1;
    end
  endgenerate

endmodule

// File: doc/onchip_mem_pipelined.md
Name: onchip_mem_pipelined

Overview:
- Parametrised single-port on-chip RAM with an Avalon-MM slave interface.
- Next generation of the system's fixed 32-bit on-chip memory: width, depth and read latency are configurable.
- Adds waitrequest/readdatavalid pipelined reads, clock-enable stall, out-of-range protection and optional zero-fill after reset.
- Sits on the system interconnect as program/data memory for the soft processor.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- DEPTH, 23040, number of words; need not be a power of two.
- ADDR_W, 15, word address width; must satisfy 2^ADDR_W >= DEPTH.
- READ_LATENCY, 1, cycles from accepted read to readdatavalid; legal values 1 or 2.
- INIT_FILE, "onchip_mem.hex", power-up contents; ignored for contents when zero-fill is compiled in.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- address  in  ADDR_W  word address
- byteenable  in  DATA_W/8  write byte lanes
- chipselect  in  1  slave select
- read  in  1  read request
- write  in  1  write request
- writedata  in  DATA_W  write data
- clken  in  1  clock enable; 0 stalls the whole block
- waitrequest  out  1  transfer not accepted this cycle
- readdata  out  DATA_W  read data, qualified by readdatavalid
- readdatavalid  out  1  readdata valid strobe

Behaviour:
- Reset is synchronous and active-low: all state is updated only on rising clk while reset_n=0.
- Reset values: waitrequest=1, readdatavalid=0, readdata=0, read pipeline cleared. Memory contents are untouched unless zero-fill is enabled.
- States:
  - RESET: held while reset_n=0.
  - INIT: only with the macro.
  - READY.
  - Without the macro, the block enters READY on the first clk after reset_n rises.
- waitrequest = (state != READY) | ~clken. Combinational from registered state and clken.
- Accept condition: chipselect & (read|write) & ~waitrequest.
- Write:
  - Lanes with byteenable[i]=1 update on the accept edge; other lanes keep their value.
  - byteenable=0 performs no update but is still accepted.
- Read:
  - Returns the word at address with readdatavalid=1 exactly READ_LATENCY clk cycles after acceptance (cycles with clken=0 are not counted).
  - Throughput: one read per cycle; back-to-back results arrive in order.
- read & write asserted together: the write is performed and the read is ignored; no readdatavalid is produced.
- Read-during-write to the same address in consecutive cycles: the read accepted after the write returns the new data. There is no same-cycle case.
- address >= DEPTH:
  - A write is accepted and discarded.
  - A read is accepted and returns all-zero with normal latency.
- clken=0:
  - RAM, read pipeline and FSM all hold.
  - readdatavalid holds its value but is not re-counted by the master. The interconnect guarantees clken=0 only when no response is pending.
- readdata holds its last value while readdatavalid=0.
- Reset mid-read: in-flight reads are discarded and no readdatavalid is issued for them.
- Reset mid-INIT: the sweep restarts from address 0.

Optional Feature:
- Macro: ONCHIP_MEM_ZERO_INIT_EN.
- Defined:
  - After reset the FSM enters INIT and writes 0 to address 0..DEPTH-1, one word per clk with clken=1, with waitrequest=1 throughout.
  - INIT→READY on the edge that writes DEPTH-1, so the sweep takes exactly DEPTH enabled cycles.
- Not defined: no INIT state; contents come from INIT_FILE at configuration only.

Decomposition:
- Package onchip_mem_pkg:
  - State enum (RESET, INIT, READY).
  - Constants MAX_READ_LATENCY=2 and BYTE_W=8.
  - A clog2 function for the sweep counter width.
- Sub-module onchip_mem_ram_core: inferred byte-enabled single-port RAM array with a one-cycle registered read and INIT_FILE initialisation.
- The top holds the FSM, accept logic, range check, extra latency stage and valid pipeline.

Test Plan:
- Write 0xDEADBEEF to addr 5 with byteenable=0xF, then read addr 5 → readdatavalid=1 with readdata=0xDEADBEEF exactly READ_LATENCY cycles after acceptance; run with READ_LATENCY=1 and 2.
- Write byteenable=0x3 data 0x11112222 over 0xDEADBEEF → read returns 0xDEAD2222.
- Four back-to-back reads of addrs 0..3 with pre-written values 0..3 → four consecutive readdatavalid pulses in order with data 0,1,2,3.
- Write 0xFFFFFFFF to addr 23040, then read addr 23040 → readdata=0, readdatavalid=1. Read addr 0 is unchanged.
- Issue a read, then drop clken for 3 cycles before the data returns → waitrequest=1 during the stall; readdatavalid is delayed by exactly 3 cycles with correct data.
- With ONCHIP_MEM_ZERO_INIT_EN and DEPTH=16:
  - Release reset → waitrequest=1 for 16 cycles, then 0.
  - Every address reads 0.
  - Reassert reset_n=0 at sweep count 7 → the sweep restarts and takes the full 16 cycles.
